// File: rtl/lsu_mem_initiator_if.sv
// Bundle of the MEM-stage request/response handshake and the word-port data memory bus.
// The slave modport is the initiator's view; master is the pipeline-plus-memory side.
interface lsu_mem_initiator_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_esc;
    logic              mem_read;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_esc, mem_read
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_esc, mem_read
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: one request at a time, byte/half lane handling on a big-endian
// word memory, read-modify-write for SB/SH, and error screening before any memory strobe.
module lsu_mem_initiator #(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 2032
) (
    input  logic                 clock,
    input  logic                 reset_n,
    lsu_mem_initiator_if.slave   bus,
    output logic [2:0]           state_dbg
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_WRITE  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t            state;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              mem_esc_q;
    logic              mem_read_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [31:0]       wdata_q;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, resp_valid is a single-cycle pulse with no back-pressure.
    logic              accept;
    logic [1:0]        off_in;
    logic [ADDR_W-1:0] word_addr;
    logic [ADDR_W:0]   last_byte;
    logic              misaligned;
    logic              out_of_range;
    logic              bad_funct3;
    logic              req_err;

    always_comb begin
        accept       = bus.req_valid && req_ready_q;
        off_in       = bus.req_addr[1:0];
        word_addr    = {bus.req_addr[ADDR_W-1:2], 2'b00};
        last_byte    = {1'b0, word_addr} + (ADDR_W+1)'(3);
        out_of_range = last_byte >= (ADDR_W+1)'(MEM_BYTES);
        misaligned   = ((bus.req_funct3[1:0] == 2'b01) && off_in[0]) ||
                       ((bus.req_funct3[1:0] == 2'b10) && (off_in != 2'b00));
        if (bus.req_store) begin
            bad_funct3 = bus.req_funct3[2] || (bus.req_funct3 == 3'b011);
        end else begin
            bad_funct3 = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                         (bus.req_funct3 == 3'b111);
        end
        req_err = misaligned || out_of_range || bad_funct3;
    end

    // Byte at offset k lives in bits [31-8k -: 8] of the word (big-endian).
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'd0, b};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                                input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] r;
        r = w;
        if (f3 == 3'b000) begin
            case (off)
                2'd0:    r[31:24] = d[7:0];
                2'd1:    r[23:16] = d[7:0];
                2'd2:    r[15:8]  = d[7:0];
                default: r[7:0]   = d[7:0];
            endcase
        end else if (f3 == 3'b001) begin
            if (off[1]) r[15:0] = d[15:0];
            else        r[31:16] = d[15:0];
        end else begin
            r = d;
        end
        return r;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'd0;
            mem_esc_q    <= 1'b0;
            mem_read_q   <= 1'b0;
            f3_q         <= 3'd0;
            off_q        <= 2'd0;
            wdata_q      <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        f3_q        <= bus.req_funct3;
                        off_q       <= off_in;
                        wdata_q     <= bus.req_wdata;
                        if (req_err) begin
                            state        <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'd0;
                        end else begin
                            mem_addr_q <= word_addr;
                            if (!bus.req_store) begin
                                mem_read_q <= 1'b1;
                                state      <= S_LOAD;
                            end else if (bus.req_funct3 == 3'b010) begin
                                mem_esc_q   <= 1'b1;
                                mem_wdata_q <= bus.req_wdata;
                                state       <= S_WRITE;
                            end else begin
                                mem_read_q <= 1'b1;
                                state      <= S_RMW_RD;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    mem_read_q   <= 1'b0;
                    resp_rdata_q <= load_ext(bus.mem_rdata, f3_q, off_q);
                    resp_err_q   <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state        <= S_RESP;
                end
                S_RMW_RD: begin
                    mem_read_q  <= 1'b0;
                    mem_esc_q   <= 1'b1;
                    mem_wdata_q <= store_merge(bus.mem_rdata, wdata_q, f3_q, off_q);
                    state       <= S_WRITE;
                end
                S_WRITE: begin
                    mem_esc_q    <= 1'b0;
                    resp_rdata_q <= 32'd0;
                    resp_err_q   <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state        <= S_RESP;
                end
                S_RESP: begin
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state        <= S_IDLE;
                end
                default: begin
                    state       <= S_IDLE;
                    req_ready_q <= 1'b1;
                    mem_esc_q   <= 1'b0;
                    mem_read_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_esc    = mem_esc_q;
    assign bus.mem_read   = mem_read_q;
    assign state_dbg      = state;
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator against a 2032-byte big-endian word memory model.
module tb_lsu_mem_initiator;
    localparam int MEM_BYTES = 2032;

    logic        clock;
    logic        reset_n;
    logic [2:0]  state_dbg;
    int          n_checks;
    int          n_pass;

    lsu_mem_initiator_if #(.ADDR_W(32)) bus ();

    lsu_mem_initiator #(.ADDR_W(32), .MEM_BYTES(MEM_BYTES)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- memory model ----------------
    logic [31:0] mem [0:507];
    logic        poke_en;
    logic [31:0] poke_addr;
    logic [31:0] poke_data;

    always @(posedge clock) begin
        if (poke_en) mem[poke_addr[10:2]] <= poke_data;
        else if (bus.mem_esc && bus.mem_addr < MEM_BYTES) mem[bus.mem_addr[10:2]] <= bus.mem_wdata;
    end

    always_comb begin
        bus.mem_rdata = 32'd0;
        if (bus.mem_addr < MEM_BYTES) bus.mem_rdata = mem[bus.mem_addr[10:2]];
    end

    function automatic logic [31:0] peek(input logic [31:0] a);
        return mem[a[10:2]];
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // ---------------- drivers ----------------
    logic [31:0] last_rdata;
    logic        last_err;
    int          last_lat;
    int          last_esc_n;
    int          last_esc_at;
    int          last_rd_n;
    int          last_both;
    logic [31:0] last_esc_wdata;

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clock);
        poke_en = 1'b0;
    endtask

    // Issue one request; latency counts cycles from the accept cycle to the resp_valid cycle.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        int n;
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
        bus.req_addr = a; bus.req_wdata = wd;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("accept_bound", {31'd0, n < 20}, 32'd1);
        @(negedge clock);
        bus.req_valid = 1'b0;
        bus.req_store = 1'($urandom_range(0, 1));
        bus.req_funct3 = 3'($urandom_range(0, 7));
        bus.req_addr = $urandom;
        bus.req_wdata = $urandom;
        last_lat = 1; last_esc_n = 0; last_esc_at = 0; last_rd_n = 0; last_both = 0;
        last_esc_wdata = 32'd0;
        while (last_lat < 20) begin
            if (bus.mem_esc) begin
                last_esc_n++; last_esc_at = last_lat; last_esc_wdata = bus.mem_wdata;
            end
            if (bus.mem_read) last_rd_n++;
            if (bus.mem_esc && bus.mem_read) last_both++;
            if (bus.resp_valid) break;
            @(negedge clock);
            last_lat++;
        end
        check("resp_bound", {31'd0, last_lat < 20}, 32'd1);
        check("esc_read_overlap", last_both, 32'd0);
        last_rdata = bus.resp_rdata;
        last_err = bus.resp_err;
    endtask

    // ---------------- stimulus ----------------
    int acc_n;
    int resp_n;
    int ovl_n;

    initial begin
        n_checks = 0; n_pass = 0;
        reset_n = 1'b0; poke_en = 1'b0; poke_addr = 32'd0; poke_data = 32'd0;
        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        repeat (3) @(negedge clock);
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        check("rst_mem_ctrl", {30'd0, bus.mem_esc, bus.mem_read}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        reset_n = 1'b1;

        poke(32'h10, 32'h807F01FF);

        do_req(1'b0, 3'b000, 32'h10, 32'd0);
        check("lb_10_data", last_rdata, 32'hFFFFFF80);
        check("lb_10_lat", last_lat, 32'd2);
        check("lb_10_err", {31'd0, last_err}, 32'd0);
        check("lb_10_reads", last_rd_n, 32'd1);
        repeat (2) @(negedge clock);
        check("resp_rdata_held", bus.resp_rdata, 32'hFFFFFF80);

        do_req(1'b0, 3'b100, 32'h13, 32'd0);
        check("lbu_13_data", last_rdata, 32'h000000FF);
        do_req(1'b0, 3'b001, 32'h12, 32'd0);
        check("lh_12_data", last_rdata, 32'h000001FF);
        do_req(1'b0, 3'b010, 32'h10, 32'd0);
        check("lw_10_data", last_rdata, 32'h807F01FF);
        do_req(1'b0, 3'b001, 32'h11, 32'd0);
        check("lh_11_err", {31'd0, last_err}, 32'd1);
        check("lh_11_rdata", last_rdata, 32'd0);
        check("lh_11_no_read", last_rd_n, 32'd0);
        check("lh_11_lat", last_lat, 32'd1);

        do_req(1'b1, 3'b000, 32'h11, 32'h000000AB);
        check("sb_11_esc_n", last_esc_n, 32'd1);
        check("sb_11_esc_at", last_esc_at, 32'd2);
        check("sb_11_wdata", last_esc_wdata, 32'h80AB01FF);
        check("sb_11_lat", last_lat, 32'd3);
        check("sb_11_mem", peek(32'h10), 32'h80AB01FF);
        do_req(1'b0, 3'b000, 32'h11, 32'd0);
        check("lb_11_data", last_rdata, 32'hFFFFFFAB);

        do_req(1'b1, 3'b001, 32'h12, 32'h00001234);
        check("sh_12_mem", peek(32'h10), 32'h80AB1234);
        do_req(1'b0, 3'b101, 32'h10, 32'd0);
        check("lhu_10_data", last_rdata, 32'h000080AB);
        do_req(1'b0, 3'b001, 32'h10, 32'd0);
        check("lh_10_data", last_rdata, 32'hFFFF80AB);

        do_req(1'b1, 3'b010, 32'h7EC, 32'hDEADBEEF);
        check("sw_7ec_lat", last_lat, 32'd2);
        check("sw_7ec_esc_at", last_esc_at, 32'd1);
        check("sw_7ec_mem", peek(32'h7EC), 32'hDEADBEEF);
        do_req(1'b0, 3'b010, 32'h7EC, 32'd0);
        check("lw_7ec_data", last_rdata, 32'hDEADBEEF);
        do_req(1'b1, 3'b010, 32'h7F0, 32'h12345678);
        check("sw_7f0_err", {31'd0, last_err}, 32'd1);
        check("sw_7f0_no_esc", last_esc_n, 32'd0);

        // Reset lands while SH is reading the word it will modify.
        poke(32'h20, 32'h11223344);
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b001;
        bus.req_addr = 32'h20; bus.req_wdata = 32'h00005566;
        @(negedge clock);
        bus.req_valid = 1'b0;
        check("sh_rst_in_rmw", {29'd0, state_dbg}, 32'd2);
        check("sh_rst_read_on", {31'd0, bus.mem_read}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("sh_rst_mem_ctrl", {30'd0, bus.mem_esc, bus.mem_read}, 32'd0);
        check("sh_rst_mem_addr", bus.mem_addr, 32'd0);
        check("sh_rst_ready", {31'd0, bus.req_ready}, 32'd1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("sh_rst_mem_kept", peek(32'h20), 32'h11223344);

        // req_valid held high: accepts only in IDLE, one per three cycles for LW.
        acc_n = 0; resp_n = 0; ovl_n = 0;
        bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h10; bus.req_wdata = 32'd0;
        for (int i = 0; i < 9; i++) begin
            if (bus.req_ready) acc_n++;
            if (bus.resp_valid) resp_n++;
            if (bus.resp_valid && bus.req_ready) ovl_n++;
            if (i < 8) @(negedge clock);
        end
        check("held_last_rdata", bus.resp_rdata, 32'h80AB1234);
        @(negedge clock);
        bus.req_valid = 1'b0;
        check("held_accepts", acc_n, 32'd3);
        check("held_resps", resp_n, 32'd3);
        check("held_ready_in_resp", ovl_n, 32'd0);

        do_req(1'b0, 3'b111, 32'h10, 32'd0);
        check("ld_f3_111_err", {31'd0, last_err}, 32'd1);
        check("ld_f3_111_no_read", last_rd_n, 32'd0);
        do_req(1'b1, 3'b011, 32'h10, 32'h0);
        check("st_f3_011_err", {31'd0, last_err}, 32'd1);
        check("st_f3_011_no_esc", last_esc_n, 32'd0);
        do_req(1'b0, 3'b010, 32'h12, 32'd0);
        check("lw_12_misaligned", {31'd0, last_err}, 32'd1);
        do_req(1'b0, 3'b010, 32'h10, 32'd0);
        check("lw_after_err", last_rdata, 32'h80AB1234);
        check("lw_after_err_flag", {31'd0, last_err}, 32'd0);

        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
